// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control bus between the multicycle controller and the MIPS datapath
interface multicycle_controller_if;
    logic [5:0] Opcode;
    logic       Jr;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] MemToReg;
    logic [1:0] RegDst;
    logic       RegWrite;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [1:0] AluOp;
    logic [1:0] PCSrc;

    modport master (
        input  Opcode, Jr,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, PCSrc
    );

    modport slave (
        output Opcode, Jr,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, PCSrc
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM sequencing the multicycle MIPS datapath
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus,
    output logic [STATE_W-1:0]      State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REXEC  = 4'd6,
        RWB    = 4'd7,
        BEQ    = 4'd8,
        JUMP   = 4'd9,
        JAL    = 4'd10,
        ADDIEX = 4'd11,
        ANDIEX = 4'd12,
        IMMWB  = 4'd13
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    stateT stateQ;
    stateT nextState;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= FETCH;
        end else begin
            stateQ <= nextState;
        end
    end

    assign State = STATE_W'(stateQ);

    always_comb begin
        nextState       = FETCH;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemToReg    = 2'b00;
        bus.RegDst      = 2'b00;
        bus.RegWrite    = 1'b0;
        bus.AluSrcA     = 1'b0;
        bus.AluSrcB     = 2'b00;
        bus.AluOp       = 2'b00;
        bus.PCSrc       = 2'b00;

        case (stateQ)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = 1'b1;
                bus.AluSrcB = 2'b01;
                bus.PCWrite = 1'b1;
                nextState   = DECODE;
            end
            DECODE: begin
                // Branch target is computed speculatively here and parked in ALUOut.
                bus.AluSrcB = 2'b11;
                case (bus.Opcode)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = REXEC;
                    OP_BEQ:       nextState = BEQ;
                    OP_J:         nextState = JUMP;
                    OP_JAL:       nextState = JAL;
                    OP_ADDI:      nextState = ADDIEX;
                    OP_ANDI:      nextState = ANDIEX;
                    default:      nextState = FETCH;
                endcase
            end
            MEMADR: begin
                bus.AluSrcA = 1'b1;
                bus.AluSrcB = 2'b10;
                nextState   = (bus.Opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                nextState   = MEMWB;
            end
            MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = 2'b01;
            end
            MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            REXEC: begin
                bus.AluSrcA = 1'b1;
                bus.AluOp   = 2'b10;
                // jr retires here; the only output that depends on an input.
                if (bus.Jr) begin
                    bus.PCWrite = 1'b1;
                    bus.PCSrc   = 2'b11;
                end else begin
                    nextState = RWB;
                end
            end
            RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 2'b01;
            end
            BEQ: begin
                bus.AluSrcA     = 1'b1;
                bus.AluOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSrc       = 2'b01;
            end
            JUMP: begin
                bus.PCWrite = 1'b1;
                bus.PCSrc   = 2'b10;
            end
            JAL: begin
                // PC still holds PC+4, so r31 picks up the return address.
                bus.PCWrite  = 1'b1;
                bus.PCSrc    = 2'b10;
                bus.RegWrite = 1'b1;
                bus.RegDst   = 2'b10;
                bus.MemToReg = 2'b10;
            end
            ADDIEX: begin
                bus.AluSrcA = 1'b1;
                bus.AluSrcB = 2'b10;
                nextState   = IMMWB;
            end
            ANDIEX: begin
                bus.AluSrcA = 1'b1;
                bus.AluSrcB = 2'b10;
                bus.AluOp   = 2'b11;
                nextState   = IMMWB;
            end
            IMMWB: begin
                bus.RegWrite = 1'b1;
            end
            default: begin
                nextState = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] State;
    int         vecCount = 0;
    int         missCount = 0;

    multicycle_controller_if bus ();

    multicycle_controller #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .State (State)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,AluSrcA,AluSrcB,AluOp,PCSrc}
    function automatic logic [17:0] getOuts();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.MemToReg, bus.RegDst, bus.RegWrite, bus.AluSrcA, bus.AluSrcB, bus.AluOp, bus.PCSrc};
    endfunction

    function automatic logic [17:0] expOuts(input int s, input bit jr);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rw = 0, srcA = 0;
        logic [1:0] m2r = 0, dst = 0, srcB = 0, aop = 0, psrc = 0;
        case (s)
            0:  begin mrd = 1; irw = 1; srcB = 2'b01; pcw = 1; end
            1:  srcB = 2'b11;
            2:  begin srcA = 1; srcB = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 2'b01; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srcA = 1; aop = 2'b10; if (jr) begin pcw = 1; psrc = 2'b11; end end
            7:  begin rw = 1; dst = 2'b01; end
            8:  begin srcA = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            9:  begin pcw = 1; psrc = 2'b10; end
            10: begin pcw = 1; psrc = 2'b10; rw = 1; dst = 2'b10; m2r = 2'b10; end
            11: begin srcA = 1; srcB = 2'b10; end
            12: begin srcA = 1; srcB = 2'b10; aop = 2'b11; end
            13: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, dst, rw, srcA, srcB, aop, psrc};
    endfunction

    // Expected state trace of one instruction, from FETCH up to its last cycle.
    function automatic void instrTrace(input logic [5:0] op, input bit jr, output int seq[$]);
        seq = {0, 1};
        case (op)
            6'b100011: seq = {seq, 2, 3, 4};
            6'b101011: seq = {seq, 2, 5};
            6'b000000: seq = jr ? {seq, 6} : {seq, 6, 7};
            6'b000100: seq = {seq, 8};
            6'b000010: seq = {seq, 9};
            6'b000011: seq = {seq, 10};
            6'b001000: seq = {seq, 11, 13};
            6'b001100: seq = {seq, 12, 13};
            default:   ;
        endcase
    endfunction

    task automatic runInstr(input logic [5:0] op, input bit jr);
        int seq[$];
        instrTrace(op, jr, seq);
        foreach (seq[i]) begin
            @(negedge clk);
            rst = 1'b1;
            if (i == 0) bus.Opcode = op;
            bus.Jr = (seq[i] == 6) ? jr : 1'($urandom);
            #1;
            checkVal($sformatf("state op=%b step%0d", op, i), 32'(State), 32'(seq[i]));
            checkVal($sformatf("outs op=%b st=%0d", op, seq[i]), 32'(getOuts()), 32'(expOuts(seq[i], jr)));
        end
    endtask

    logic [5:0] legalOps [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                 6'b000010, 6'b000011, 6'b001000, 6'b001100};

    initial begin
        bus.Opcode = 6'b000000;
        bus.Jr     = 1'b0;

        // Held in reset across edges: FETCH outputs, state pinned at 0.
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset state", 32'(State), 32'd0);
        checkVal("reset outs", 32'(getOuts()), 32'(expOuts(0, 1'b0)));

        runInstr(6'b000100, 1'b0);
        runInstr(6'b100011, 1'b0);
        runInstr(6'b101011, 1'b0);
        runInstr(6'b001100, 1'b0);
        runInstr(6'b000000, 1'b0);
        runInstr(6'b000000, 1'b1);
        runInstr(6'b000011, 1'b0);
        runInstr(6'b111111, 1'b0);

        // Async reset while a store is in MEMWR.
        @(negedge clk); bus.Opcode = 6'b101011; bus.Jr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkVal("sw reach memwr", 32'(State), 32'd5);
        checkVal("sw memwrite", 32'(bus.MemWrite), 32'd1);
        #1 rst = 1'b0;
        #1;
        checkVal("async rst state", 32'(State), 32'd0);
        checkVal("async rst memwrite", 32'(bus.MemWrite), 32'd0);
        checkVal("async rst outs", 32'(getOuts()), 32'(expOuts(0, 1'b0)));
        @(posedge clk);
        #1;
        checkVal("rst hold state", 32'(State), 32'd0);
        runInstr(6'b001000, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legalOps[$urandom_range(0, 7)];
            runInstr(op, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
